// File: rtl/heap_interval_store_if.sv
// -----------------------------------------------------------------------------
// heap_interval_store_if
// Bus bundle between the branch unit / debug side and heap_interval_store.
//   clr_i           synchronous clear of the whole table
//   en_write_i      write strobe for addr_first_i/addr_last_i
//   addr_first_i    interval start, inclusive
//   addr_last_i     interval end, inclusive
//   find_addr_i     lookup address
//   addr_in_range_o lookup hit (combinational)
//   hit_idx_o       lowest hitting entry index, 0 on miss (combinational)
//   read_idx_i      debug entry select
//   read_o/read2_o  registered first/last of the selected entry
//   count_o         number of valid entries
//   full_o          count_o == DEPTH
//   ovf_o           sticky eviction flag
//   hit_cnt_o       saturating hit counter, present only when
//                   HEAP_INTERVAL_STORE_HIT_CNT_EN is defined
// Modports: master drives the requests, slave is the store itself.
// -----------------------------------------------------------------------------
interface heap_interval_store_if #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
);
  localparam int IW = $clog2(DEPTH);

  logic          clr_i;
  logic          en_write_i;
  logic [AW-1:0] addr_first_i;
  logic [AW-1:0] addr_last_i;
  logic [AW-1:0] find_addr_i;
  logic          addr_in_range_o;
  logic [IW-1:0] hit_idx_o;
  logic [IW-1:0] read_idx_i;
  logic [AW-1:0] read_o;
  logic [AW-1:0] read2_o;
  logic [IW:0]   count_o;
  logic          full_o;
  logic          ovf_o;
`ifdef HEAP_INTERVAL_STORE_HIT_CNT_EN
  logic [15:0]   hit_cnt_o;
`endif

  modport master (
    output clr_i, en_write_i, addr_first_i, addr_last_i, find_addr_i, read_idx_i,
    input  addr_in_range_o, hit_idx_o, read_o, read2_o, count_o, full_o, ovf_o
`ifdef HEAP_INTERVAL_STORE_HIT_CNT_EN
    , input hit_cnt_o
`endif
  );

  modport slave (
    input  clr_i, en_write_i, addr_first_i, addr_last_i, find_addr_i, read_idx_i,
    output addr_in_range_o, hit_idx_o, read_o, read2_o, count_o, full_o, ovf_o
`ifdef HEAP_INTERVAL_STORE_HIT_CNT_EN
    , output hit_cnt_o
`endif
  );
endinterface

// File: rtl/heap_interval_store.sv
// -----------------------------------------------------------------------------
// heap_interval_store
// Storage/lookup end of the heap-overflow guard. Keeps the most recent DEPTH
// closed store intervals {first, last} in a circular table, merges a new
// interval into the newest entry when they overlap or touch, and answers in
// the same cycle whether find_addr_i lies inside any valid entry.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   bus    heap_interval_store_if.slave (see the interface for signal list)
//
// Optional feature: define HEAP_INTERVAL_STORE_HIT_CNT_EN to add the 16-bit
// saturating hit counter bus.hit_cnt_o.
// -----------------------------------------------------------------------------
module heap_interval_store #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input logic                  clk_i,
  input logic                  rst_i,
  heap_interval_store_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [IW-1:0] PTR_ONE  = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   END_ONE  = {{AW{1'b0}}, 1'b1};

  // Table state
  logic [AW-1:0]    first_q [DEPTH];
  logic [AW-1:0]    last_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [IW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    read_q, read2_q;

  // Write decode
  logic [IW-1:0]    newest_s;
  logic [AW:0]      newest_end_s;
  logic [AW-1:0]    merge_last_s;
  logic             wr_ok_s;
  logic             merge_s;
  logic             alloc_s;

  // Lookup
  logic [DEPTH-1:0] hit_vec_s;
  logic [IW-1:0]    hit_idx_s;

  // Per-entry hit vector over the registered table; valid masks stale payload
  always_comb begin
    hit_vec_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec_s[i] = valid_q[i] &&
                     (first_q[i] <= bus.find_addr_i) &&
                     (bus.find_addr_i <= last_q[i]);
    end
  end

  // Lowest hitting index wins: scan downwards so the last assignment is the lowest
  always_comb begin
    hit_idx_s = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx_s = hit_vec_s[i] ? IW'(i) : hit_idx_s;
    end
  end

  // Merge/allocate decision and next pointer, count and overflow
  always_comb begin
    newest_s     = wr_ptr_q - PTR_ONE;
    // last+1 in AW+1 bits so an entry ending at the top never touches address 0
    newest_end_s = {1'b0, last_q[newest_s]} + END_ONE;
    wr_ok_s      = bus.en_write_i && (bus.addr_first_i <= bus.addr_last_i);
    merge_s      = wr_ok_s && valid_q[newest_s] &&
                   (first_q[newest_s] <= bus.addr_first_i) &&
                   ({1'b0, bus.addr_first_i} <= newest_end_s);
    alloc_s      = wr_ok_s && !merge_s;
    merge_last_s = (bus.addr_last_i > last_q[newest_s]) ? bus.addr_last_i : last_q[newest_s];
    wr_ptr_d     = alloc_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    if (alloc_s && !valid_q[wr_ptr_q]) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
    ovf_d = ovf_q || (alloc_s && valid_q[wr_ptr_q]);
  end

  // Valid bits, pointer, count, sticky overflow and the registered debug read
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      read_q   <= '0;
      read2_q  <= '0;
    end else if (bus.clr_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      read_q   <= '0;
      read2_q  <= '0;
    end else begin
      if (alloc_s) begin
        valid_q[wr_ptr_q] <= 1'b1;
      end
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      // Pre-write view of the selected entry; a same-cycle write shows next cycle
      read_q   <= valid_q[bus.read_idx_i] ? first_q[bus.read_idx_i] : '0;
      read2_q  <= valid_q[bus.read_idx_i] ? last_q[bus.read_idx_i]  : '0;
    end
  end

  // Entry payload; left unreset because every consumer masks it with valid
  always_ff @(posedge clk_i) begin
    if (alloc_s) begin
      first_q[wr_ptr_q] <= bus.addr_first_i;
      last_q[wr_ptr_q]  <= bus.addr_last_i;
    end else if (merge_s) begin
      last_q[newest_s]  <= merge_last_s;
    end
  end

`ifdef HEAP_INTERVAL_STORE_HIT_CNT_EN
  logic [15:0] hit_cnt_q;

  // Saturating count of cycles with a lookup hit
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q <= 16'h0000;
    end else if (bus.clr_i) begin
      hit_cnt_q <= 16'h0000;
    end else if ((|hit_vec_s) && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_q <= hit_cnt_q + 16'h0001;
    end
  end

  assign bus.hit_cnt_o = hit_cnt_q;
`endif

  assign bus.addr_in_range_o = |hit_vec_s;
  assign bus.hit_idx_o       = hit_idx_s;
  assign bus.read_o          = read_q;
  assign bus.read2_o         = read2_q;
  assign bus.count_o         = count_q;
  assign bus.full_o          = (count_q == CNT_FULL);
  assign bus.ovf_o           = ovf_q;

endmodule

// File: tb/tb_heap_interval_store.sv
// -----------------------------------------------------------------------------
// tb_heap_interval_store
// Self-checking bench for heap_interval_store: directed scenarios from the
// block's test plan plus a randomized run, all compared against a behavioural
// model of the interval table kept here.
// -----------------------------------------------------------------------------
module tb_heap_interval_store;
  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int IW    = 3;

  logic clk = 1'b0;
  logic rst;

  heap_interval_store_if #(.DEPTH(DEPTH), .AW(AW)) bus ();
  heap_interval_store #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: slots, insertion pointer, count, sticky overflow
  logic [AW-1:0] m_first [DEPTH];
  logic [AW-1:0] m_last  [DEPTH];
  bit            m_valid [DEPTH];
  int            m_ptr;
  int            m_count;
  bit            m_ovf;
  logic [AW-1:0] m_rd;
  logic [AW-1:0] m_rd2;

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_ptr = 0; m_count = 0; m_ovf = 1'b0; m_rd = '0; m_rd2 = '0;
  endfunction

  function automatic void model_write(input logic [AW-1:0] f, input logic [AW-1:0] l);
    int n;
    if (f > l) return;
    n = (m_ptr + DEPTH - 1) % DEPTH;
    if (m_valid[n] && f >= m_first[n] && {32'h0, f} <= {32'h0, m_last[n]} + 64'd1) begin
      if (l > m_last[n]) m_last[n] = l;
      return;
    end
    if (m_valid[m_ptr]) m_ovf = 1'b1;
    else m_count++;
    m_first[m_ptr] = f; m_last[m_ptr] = l; m_valid[m_ptr] = 1'b1;
    m_ptr = (m_ptr + 1) % DEPTH;
  endfunction

  function automatic void model_find(input logic [AW-1:0] a, output bit hit, output logic [IW-1:0] idx);
    hit = 1'b0; idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && a >= m_first[i] && a <= m_last[i]) begin
        hit = 1'b1; idx = IW'(i);
      end
    end
  endfunction

  // One clock: update the model with the inputs as the edge will see them
  task automatic tick();
    if (bus.clr_i) begin
      model_clear();
    end else begin
      m_rd  = m_valid[bus.read_idx_i] ? m_first[bus.read_idx_i] : '0;
      m_rd2 = m_valid[bus.read_idx_i] ? m_last[bus.read_idx_i]  : '0;
      if (bus.en_write_i) model_write(bus.addr_first_i, bus.addr_last_i);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [AW-1:0] f, input logic [AW-1:0] l);
    bus.en_write_i = 1'b1; bus.addr_first_i = f; bus.addr_last_i = l;
    tick();
    bus.en_write_i = 1'b0;
  endtask

  task automatic do_clear();
    bus.clr_i = 1'b1; tick(); bus.clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clr_i = 1'b0; bus.en_write_i = 1'b0; bus.addr_first_i = '0; bus.addr_last_i = '0;
    bus.find_addr_i = '0; bus.read_idx_i = '0;
    model_clear();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
    checks++; if (bus.full_o !== 1'b0 || bus.ovf_o !== 1'b0) begin errors++; $display("FAIL reset_flags got full=%b ovf=%b exp 0 0", bus.full_o, bus.ovf_o); end
    checks++; if (bus.read_o !== 32'h0 || bus.read2_o !== 32'h0) begin errors++; $display("FAIL reset_read got %h %h exp 0 0", bus.read_o, bus.read2_o); end
    checks++; if (bus.addr_in_range_o !== 1'b0 || bus.hit_idx_o !== 3'd0) begin errors++; $display("FAIL reset_lookup got hit=%b idx=%0d exp 0 0", bus.addr_in_range_o, bus.hit_idx_o); end
  endtask

  task automatic test_basic_lookup();
    do_write(32'h80001000, 32'h80001040);
    bus.find_addr_i = 32'h80001040; #1;
    checks++; if (bus.addr_in_range_o !== 1'b1 || bus.hit_idx_o !== 3'd0) begin errors++; $display("FAIL basic_hit got hit=%b idx=%0d exp 1 0", bus.addr_in_range_o, bus.hit_idx_o); end
    checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL basic_count got %0d exp 1", bus.count_o); end
    bus.find_addr_i = 32'h80001044; #1;
    checks++; if (bus.addr_in_range_o !== 1'b0) begin errors++; $display("FAIL basic_miss got %b exp 0", bus.addr_in_range_o); end
    bus.find_addr_i = 32'h80000FFF; #1;
    checks++; if (bus.addr_in_range_o !== 1'b0) begin errors++; $display("FAIL basic_below got %b exp 0", bus.addr_in_range_o); end
  endtask

  task automatic test_merge();
    do_clear();
    do_write(32'h1000, 32'h1020);
    do_write(32'h1021, 32'h1060);
    checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL merge_count got %0d exp 1", bus.count_o); end
    bus.read_idx_i = 3'd0; tick();
    checks++; if (bus.read_o !== 32'h1000 || bus.read2_o !== 32'h1060) begin errors++; $display("FAIL merge_read got %h %h exp 00001000 00001060", bus.read_o, bus.read2_o); end
    do_write(32'h2000, 32'h2010);
    checks++; if (bus.count_o !== 4'd2) begin errors++; $display("FAIL merge_alloc_count got %0d exp 2", bus.count_o); end
    // Near the top of the address space: no wrap into an interval at 0
    do_clear();
    do_write(32'hFFFFFF00, 32'hFFFFFFFF);
    do_write(32'h00000000, 32'h00000010);
    checks++; if (bus.count_o !== 4'd2) begin errors++; $display("FAIL nowrap_count got %0d exp 2", bus.count_o); end
    bus.find_addr_i = 32'hFFFFFFFF; #1;
    checks++; if (bus.addr_in_range_o !== 1'b1 || bus.hit_idx_o !== 3'd0) begin errors++; $display("FAIL top_hit got hit=%b idx=%0d exp 1 0", bus.addr_in_range_o, bus.hit_idx_o); end
    // Single-address interval
    do_write(32'h5000, 32'h5000);
    for (int k = 0; k < 3; k++) begin
      bus.find_addr_i = 32'h4FFF + 32'(k); #1;
      checks++;
      if (bus.addr_in_range_o !== (k == 1)) begin errors++; $display("FAIL single_addr %h got %b exp %b", bus.find_addr_i, bus.addr_in_range_o, (k == 1)); end
    end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int k = 1; k <= 9; k++) do_write(32'(k) * 32'h100, 32'(k) * 32'h100 + 32'h10);
    checks++; if (bus.full_o !== 1'b1 || bus.ovf_o !== 1'b1 || bus.count_o !== 4'd8) begin errors++; $display("FAIL ovf_status got full=%b ovf=%b cnt=%0d exp 1 1 8", bus.full_o, bus.ovf_o, bus.count_o); end
    bus.find_addr_i = 32'h105; #1;
    checks++; if (bus.addr_in_range_o !== 1'b0) begin errors++; $display("FAIL ovf_evicted got %b exp 0", bus.addr_in_range_o); end
    bus.find_addr_i = 32'h905; #1;
    checks++; if (bus.addr_in_range_o !== 1'b1 || bus.hit_idx_o !== 3'd0) begin errors++; $display("FAIL ovf_newest got hit=%b idx=%0d exp 1 0", bus.addr_in_range_o, bus.hit_idx_o); end
    bus.find_addr_i = 32'h205; #1;
    checks++; if (bus.addr_in_range_o !== 1'b1 || bus.hit_idx_o !== 3'd1) begin errors++; $display("FAIL ovf_second got hit=%b idx=%0d exp 1 1", bus.addr_in_range_o, bus.hit_idx_o); end
  endtask

  task automatic test_invalid_and_clr();
    do_clear();
    do_write(32'h200, 32'h2FF);
    do_write(32'h300, 32'h200);
    checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL inverted_count got %0d exp 1", bus.count_o); end
    bus.find_addr_i = 32'h280; #1;
    checks++; if (bus.addr_in_range_o !== 1'b1) begin errors++; $display("FAIL inverted_keep got %b exp 1", bus.addr_in_range_o); end
    bus.find_addr_i = 32'h300; #1;
    checks++; if (bus.addr_in_range_o !== 1'b0) begin errors++; $display("FAIL inverted_ignored got %b exp 0", bus.addr_in_range_o); end
    bus.clr_i = 1'b1; bus.en_write_i = 1'b1; bus.addr_first_i = 32'h300; bus.addr_last_i = 32'h310;
    tick();
    bus.clr_i = 1'b0; bus.en_write_i = 1'b0;
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", bus.count_o); end
    bus.find_addr_i = 32'h305; #1;
    checks++; if (bus.addr_in_range_o !== 1'b0) begin errors++; $display("FAIL clr_write_dropped got %b exp 0", bus.addr_in_range_o); end
  endtask

  task automatic test_async_reset();
    do_clear();
    do_write(32'h100, 32'h1FF);
    do_write(32'h400, 32'h4FF);
    do_write(32'h800, 32'h8FF);
    bus.read_idx_i = 3'd1; tick();
    bus.en_write_i = 1'b1; bus.addr_first_i = 32'hA00; bus.addr_last_i = 32'hAFF;
    bus.find_addr_i = 32'h450;
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.count_o !== 4'd0 || bus.ovf_o !== 1'b0 || bus.full_o !== 1'b0) begin errors++; $display("FAIL arst_status got cnt=%0d ovf=%b full=%b exp 0 0 0", bus.count_o, bus.ovf_o, bus.full_o); end
    checks++; if (bus.read_o !== 32'h0 || bus.read2_o !== 32'h0 || bus.addr_in_range_o !== 1'b0 || bus.hit_idx_o !== 3'd0) begin errors++; $display("FAIL arst_outputs got rd=%h rd2=%h hit=%b idx=%0d exp 0", bus.read_o, bus.read2_o, bus.addr_in_range_o, bus.hit_idx_o); end
    @(posedge clk); #1;
    rst = 1'b0; bus.en_write_i = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL arst_count_after got %0d exp 0", bus.count_o); end
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] probe [4];
      probe[0] = 32'h150; probe[1] = 32'h450; probe[2] = 32'h850; probe[3] = 32'hA50;
      bus.find_addr_i = probe[k]; #1;
      checks++; if (bus.addr_in_range_o !== 1'b0) begin errors++; $display("FAIL arst_lost %h got %b exp 0", probe[k], bus.addr_in_range_o); end
    end
  endtask

  task automatic test_random();
    bit            eh;
    logic [IW-1:0] ei;
    logic [AW-1:0] base, f, l;
    do_clear();
    for (int n = 0; n < 600; n++) begin
      base = ($urandom_range(0, 15) == 0) ? 32'hFFFFFF00 : 32'h0;
      f = base + 32'($urandom_range(0, 255));
      l = ($urandom_range(0, 9) == 0) ? f - 32'd3 : f + 32'($urandom_range(0, 24));
      bus.en_write_i   = ($urandom_range(0, 3) != 0);
      bus.addr_first_i = f;
      bus.addr_last_i  = l;
      bus.clr_i        = ($urandom_range(0, 60) == 0);
      bus.read_idx_i   = IW'($urandom_range(0, DEPTH - 1));
      tick();
      bus.find_addr_i = base + 32'($urandom_range(0, 290));
      #1;
      model_find(bus.find_addr_i, eh, ei);
      checks++;
      if (bus.addr_in_range_o !== eh || bus.hit_idx_o !== ei) begin errors++; $display("FAIL rnd_lookup n=%0d addr=%h got hit=%b idx=%0d exp %b %0d", n, bus.find_addr_i, bus.addr_in_range_o, bus.hit_idx_o, eh, ei); end
      checks++;
      if (bus.count_o !== 4'(m_count) || bus.full_o !== (m_count == DEPTH) || bus.ovf_o !== m_ovf) begin errors++; $display("FAIL rnd_status n=%0d got cnt=%0d full=%b ovf=%b exp %0d %b %b", n, bus.count_o, bus.full_o, bus.ovf_o, m_count, (m_count == DEPTH), m_ovf); end
      checks++;
      if (bus.read_o !== m_rd || bus.read2_o !== m_rd2) begin errors++; $display("FAIL rnd_read n=%0d got %h %h exp %h %h", n, bus.read_o, bus.read2_o, m_rd, m_rd2); end
    end
    bus.en_write_i = 1'b0; bus.clr_i = 1'b0;
  endtask

`ifdef HEAP_INTERVAL_STORE_HIT_CNT_EN
  task automatic test_hit_cnt();
    do_clear();
    do_write(32'h7000, 32'h70FF);
    bus.find_addr_i = 32'h7010;
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (bus.hit_cnt_o !== 16'hFFFF) begin errors++; $display("FAIL hit_cnt_sat got %h exp ffff", bus.hit_cnt_o); end
    do_clear();
    checks++; if (bus.hit_cnt_o !== 16'h0000) begin errors++; $display("FAIL hit_cnt_clr got %h exp 0000", bus.hit_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_lookup();
    test_merge();
    test_overflow();
    test_invalid_and_clr();
    test_async_reset();
    test_random();
`ifdef HEAP_INTERVAL_STORE_HIT_CNT_EN
    test_hit_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
